float64_mul_seq: RTL

FLOAT64_MUL_SEQ -- requirements
Module: float64_mul_seq

---
 rtl/float64_mul_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/float64_mul_seq.sv
// Sequential IEEE-754 binary64 multiplier using an ap_ctrl handshake.
// Normal operands take a 53-cycle shift-add multiply, then normalization and round-to-nearest-even. No denormal outputs are produced.
module float64_mul_seq #(
    parameter logic [63:0] DEFAULT_NAN = 64'h7FF8000000000000
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        ap_ready,
    output logic        ap_idle,
    output logic        ap_done,
    output logic [63:0] ap_return
);

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
    state_t state, state_nxt;

    logic [52:0]  mcand, mplier, mant;
    logic [105:0] prod;
    logic [5:0]   cnt;
    logic [12:0]  exp_r;
    logic         sign_r, guard, sticky;

    // Operand classification; denormals are treated as zero.
    logic a_zd, b_zd, a_inf, b_inf, a_nan, b_nan, sgn;
    assign a_zd  = (a[62:52] == 11'd0);
    assign b_zd  = (b[62:52] == 11'd0);
    assign a_inf = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    assign b_inf = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    assign a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    assign b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    assign sgn   = a[63] ^ b[63];

    logic        special;
    logic [63:0] special_val;
    always_comb begin
        special     = 1'b1;
        special_val = 64'd0;
        if (a_nan || b_nan)                        special_val = DEFAULT_NAN;
        else if ((a_inf && b_zd) || (b_inf && a_zd)) special_val = DEFAULT_NAN;
        else if (a_inf || b_inf)                   special_val = {sgn, 11'h7FF, 52'd0};
        else if (a_zd || b_zd)                     special_val = {sgn, 63'd0};
        else                                       special     = 1'b0;
    end

    logic [12:0] exp_sum;
    assign exp_sum = {2'b00, a[62:52]} + {2'b00, b[62:52]} - 13'd1023;

    // Right-shifting accumulator: the upper half absorbs one partial product per cycle.
    logic [53:0] acc_sum;
    assign acc_sum = {1'b0, prod[105:53]} + {1'b0, (mplier[0] ? mcand : 53'd0)};

    logic        rnd_up;
    logic [53:0] rnd_m;
    logic [51:0] r_frac;
    logic [12:0] r_exp;
    logic [63:0] r_val;
    always_comb begin
        rnd_up = guard & (sticky | mant[0]);
        rnd_m  = {1'b0, mant} + {53'd0, rnd_up};
        r_frac = rnd_m[53] ? rnd_m[52:1] : rnd_m[51:0];
        r_exp  = exp_r + {12'd0, rnd_m[53]};
        if ($signed(r_exp) >= 13'sd2047)   r_val = {sign_r, 11'h7FF, 52'd0};
        else if ($signed(r_exp) <= 13'sd0) r_val = {sign_r, 63'd0};
        else                               r_val = {sign_r, r_exp[10:0], r_frac};
    end

    assign ap_ready = ap_rst_n && (state == IDLE) && ap_start;
    assign ap_idle  = (state == IDLE) && !ap_start;
    assign ap_done  = (state == DONE);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_ready) state_nxt = special ? DONE : MUL;
            MUL:     if (cnt == 6'd52) state_nxt = NORM;
            NORM:    state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            mant      <= '0;
            cnt       <= '0;
            exp_r     <= '0;
            sign_r    <= 1'b0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            ap_return <= '0;
        end else begin
            case (state)
                IDLE: if (ap_ready) begin
                    sign_r <= sgn;
                    mcand  <= {1'b1, a[51:0]};
                    mplier <= {1'b1, b[51:0]};
                    prod   <= '0;
                    cnt    <= '0;
                    exp_r  <= exp_sum;
                    if (special) ap_return <= special_val;
                end
                MUL: begin
                    prod   <= {acc_sum, prod[52:1]};
                    mplier <= {1'b0, mplier[52:1]};
                    cnt    <= cnt + 6'd1;
                end
                NORM: begin
                    if (prod[105]) begin
                        mant   <= prod[105:53];
                        guard  <= prod[52];
                        sticky <= |prod[51:0];
                        exp_r  <= exp_r + 13'd1;
                    end else begin
                        mant   <= prod[104:52];
                        guard  <= prod[51];
                        sticky <= |prod[50:0];
                    end
                end
                ROUND:   ap_return <= r_val;
                default: ;
            endcase
        end
    end

endmodule
